// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: hazard inputs from the ID/EX region and pipeline control outputs
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             IDEX_MemRead;
    logic             IDEX_Mul;
    logic [4:0]       IDEXRt;
    logic [4:0]       IFIDRs;
    logic [4:0]       IFIDRt;
    logic             Branch_Taken;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IDEXWrite;
    logic             IFID_Flush;
    logic             IDEX_Bubble;
    logic             EXMEM_Bubble;
    logic             Busy;
    logic [CNT_W-1:0] StallCount;
    modport master (
        output IDEX_MemRead, IDEX_Mul, IDEXRt, IFIDRs, IFIDRt, Branch_Taken,
        input  PCWrite, IFIDWrite, IDEXWrite, IFID_Flush, IDEX_Bubble, EXMEM_Bubble, Busy, StallCount
    );
    modport slave (
        input  IDEX_MemRead, IDEX_Mul, IDEXRt, IFIDRs, IFIDRt, Branch_Taken,
        output PCWrite, IFIDWrite, IDEXWrite, IFID_Flush, IDEX_Bubble, EXMEM_Bubble, Busy, StallCount
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: load-use, branch-flush and multiply-hold scheduler for the 5-stage pipeline
module pipe_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input logic         clk,
    input logic         reset,
    pipe_stall_ctrl_if.slave p
);
    typedef enum logic {RUN, BUSY} state_t;
    localparam logic [3:0] LAST  = 4'(MUL_LAT - 1);
    localparam logic       MULTI = MUL_LAT > 1;
    state_t           state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic [CNT_W-1:0] stall_cnt;
    logic             mul_start, hold, mul_stall, load_use;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (!p.PCWrite && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
    // release cycle (cnt == LAST) is not a hold: the multiply leaves EX and a new one is seen in RUN
    always_comb begin
        mul_start      = MULTI && state == RUN && p.IDEX_Mul;
        hold           = state == BUSY && cnt != LAST;
        mul_stall      = !reset && (mul_start || hold);
        load_use       = !reset && !mul_stall && p.IDEX_MemRead && p.IDEXRt != 5'd0 &&
                         (p.IDEXRt == p.IFIDRs || p.IDEXRt == p.IFIDRt);
        state_n        = (mul_start || hold) ? BUSY : RUN;
        cnt_n          = mul_start ? 4'd1 : hold ? cnt + 4'd1 : 4'd0;
        p.PCWrite      = !(mul_stall || load_use);
        p.IFIDWrite    = !(mul_stall || load_use);
        p.IDEXWrite    = !mul_stall;
        p.IFID_Flush   = !reset && p.Branch_Taken && !mul_stall && !load_use;
        p.IDEX_Bubble  = load_use;
        p.EXMEM_Bubble = mul_stall;
        p.Busy         = !reset && state == BUSY;
        p.StallCount   = stall_cnt;
    end
endmodule
